stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/bcd_digit_counter.sv | 41 ++++
 rtl/stopwatch_core.sv | 138 +++++++++++++
 tb/tb_stopwatch_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM states, digit width,
// per-digit moduli and the packed six-digit display type.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 6;

    localparam int unsigned CS_O_MOD  = 10;
    localparam int unsigned CS_T_MOD  = 10;
    localparam int unsigned SEC_O_MOD = 10;
    localparam int unsigned SEC_T_MOD = 6;
    localparam int unsigned MIN_O_MOD = 10;

    typedef logic [NUM_DIGITS*DIGIT_W-1:0] display_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2,
        StLap    = 2'd3
    } sw_state_e;

    // Highest legal value of a digit with the given modulus.
    function automatic logic [DIGIT_W-1:0] digit_last(input int unsigned modulus);
        return DIGIT_W'(modulus - 1);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with synchronous clear, increment enable and a
// combinational carry that fires on the increment that wraps the digit.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MOD = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] LastVal = digit_last(MOD);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            // >= rather than == so a corrupted digit still falls back into range.
            digit_d = (digit_q >= LastVal) ? '0 : digit_q + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == LastVal);

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS.cc stopwatch with run/pause/clear control and saturate-or-wrap at full count.
// Define STOPWATCH_LAP_HOLD_EN to build in the lap display freeze.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MIN_TENS = 5,
    parameter int unsigned SAT_ON_MAX   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_en,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] display_bcd,
    output logic        running,
    output logic        overflow
);

    // Asynchronous assert, synchronous release.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    sw_state_e state_q, state_d;
    logic      running_q, overflow_q, overflow_d;
    logic      counting, tick_hit, sat_hit, count_en, at_max, lap_req;

    logic [DIGIT_W-1:0] cs_o, cs_t, sec_o, sec_t, min_o, min_t;
    logic               cy_cs_o, cy_cs_t, cy_sec_o, cy_sec_t, cy_min_o, unused_carry;
    display_t           live;

    bcd_digit_counter #(.MOD(CS_O_MOD)) u_cs_o (
        .clock(clock), .reset(rst_sync_q), .clr(clear), .inc(count_en),
        .digit(cs_o), .carry(cy_cs_o)
    );
    bcd_digit_counter #(.MOD(CS_T_MOD)) u_cs_t (
        .clock(clock), .reset(rst_sync_q), .clr(clear), .inc(cy_cs_o),
        .digit(cs_t), .carry(cy_cs_t)
    );
    bcd_digit_counter #(.MOD(SEC_O_MOD)) u_sec_o (
        .clock(clock), .reset(rst_sync_q), .clr(clear), .inc(cy_cs_t),
        .digit(sec_o), .carry(cy_sec_o)
    );
    bcd_digit_counter #(.MOD(SEC_T_MOD)) u_sec_t (
        .clock(clock), .reset(rst_sync_q), .clr(clear), .inc(cy_sec_o),
        .digit(sec_t), .carry(cy_sec_t)
    );
    bcd_digit_counter #(.MOD(MIN_O_MOD)) u_min_o (
        .clock(clock), .reset(rst_sync_q), .clr(clear), .inc(cy_sec_t),
        .digit(min_o), .carry(cy_min_o)
    );
    // The top carry is not needed: a full wrap already lands every digit on zero.
    bcd_digit_counter #(.MOD(MAX_MIN_TENS + 1)) u_min_t (
        .clock(clock), .reset(rst_sync_q), .clr(clear), .inc(cy_min_o),
        .digit(min_t), .carry(unused_carry)
    );

    assign live   = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
    assign at_max = (cs_o  == digit_last(CS_O_MOD))  && (cs_t  == digit_last(CS_T_MOD))  &&
                    (sec_o == digit_last(SEC_O_MOD)) && (sec_t == digit_last(SEC_T_MOD)) &&
                    (min_o == digit_last(MIN_O_MOD)) && (min_t == digit_last(MAX_MIN_TENS + 1));

`ifdef STOPWATCH_LAP_HOLD_EN
    display_t hold_q;

    assign lap_req = lap;

    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            hold_q <= '0;
        end else if (state_q != StLap && state_d == StLap) begin
            hold_q <= live;
        end
    end

    assign display_bcd = (state_q == StLap) ? hold_q : live;
`else
    logic unused_lap;

    assign unused_lap  = lap;
    assign lap_req     = 1'b0;
    assign display_bcd = live;
`endif

    always_comb begin
        state_d    = state_q;
        counting   = (state_q == StRun) || (state_q == StLap);
        tick_hit   = tick_en && counting && !clear;
        sat_hit    = tick_hit && at_max && (SAT_ON_MAX != 0);
        count_en   = tick_hit && !sat_hit;
        overflow_d = overflow_q || (tick_hit && at_max);

        if (clear) begin
            state_d    = StIdle;
            overflow_d = 1'b0;
        end else if (start_stop) begin
            unique case (state_q)
                StIdle:   state_d = StRun;
                StRun:    state_d = StPaused;
                StPaused: state_d = StRun;
                StLap:    state_d = StPaused;
                default:  state_d = StIdle;
            endcase
        end else if (lap_req && state_q == StRun) begin
            state_d = StLap;
        end else if (lap_req && state_q == StLap) begin
            state_d = StRun;
        end else if (sat_hit) begin
            // Explicit control pulses outrank the automatic stop at full count.
            state_d = StPaused;
        end
    end

    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= StIdle;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == StRun) || (state_d == StLap);
            overflow_q <= overflow_d;
        end
    end

    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: three instances (saturating, wrapping, default params)
// compared against a centisecond-count reference model.
module tb_stopwatch_core;

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam bit LapEn = 1'b1;
`else
    localparam bit LapEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_ab, reset_c;
    logic tick_en, start_stop, start_stop_c, clear, lap;
    logic [23:0] disp0, disp1, disp2;
    logic run0, run1, run2, ovf0, ovf1, ovf2;

    always #5 clock = ~clock;

    stopwatch_core #(.MAX_MIN_TENS(0), .SAT_ON_MAX(1)) dut_sat (
        .clock(clock), .reset(reset_ab), .tick_en(tick_en), .start_stop(start_stop),
        .clear(clear), .lap(lap), .display_bcd(disp0), .running(run0), .overflow(ovf0)
    );
    stopwatch_core #(.MAX_MIN_TENS(0), .SAT_ON_MAX(0)) dut_wrap (
        .clock(clock), .reset(reset_ab), .tick_en(tick_en), .start_stop(start_stop),
        .clear(clear), .lap(lap), .display_bcd(disp1), .running(run1), .overflow(ovf1)
    );
    stopwatch_core dut_dflt (
        .clock(clock), .reset(reset_c), .tick_en(tick_en), .start_stop(start_stop_c),
        .clear(clear), .lap(lap), .display_bcd(disp2), .running(run2), .overflow(ovf2)
    );

    int n_checks = 0;
    int n_err = 0;
    int track_err = 0;
    int bad_bcd = 0;

    // Model: count in centiseconds, state 0 idle / 1 run / 2 paused / 3 lap.
    int m_cs[3], m_st[3], m_hold[3], skip[3];
    bit m_ovf[3];
    int m_max[3] = '{59999, 59999, 359999};
    bit m_sat[3] = '{1'b1, 1'b0, 1'b1};
    int m_mt[3]  = '{0, 0, 5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [25:0] exp_vec(input int i);
        logic [23:0] d;
        d = (m_st[i] == 3) ? to_bcd(m_hold[i]) : to_bcd(m_cs[i]);
        return {d, logic'(m_st[i] == 1 || m_st[i] == 3), m_ovf[i]};
    endfunction

    function automatic logic [25:0] obs(input int i);
        case (i)
            0:       return {disp0, run0, ovf0};
            1:       return {disp1, run1, ovf1};
            default: return {disp2, run2, ovf2};
        endcase
    endfunction

    function automatic logic rst_sig(input int i);
        return (i < 2) ? reset_ab : reset_c;
    endfunction

    task automatic model_reset(input int i);
        m_cs[i] = 0; m_st[i] = 0; m_ovf[i] = 1'b0; m_hold[i] = 0;
    endtask

    task automatic model_step(input int i, input bit ss, input bit clr, input bit lp,
                              input bit tk);
        int nst, prev;
        bit sat_hit;
        prev = m_cs[i];
        nst = m_st[i];
        sat_hit = 1'b0;
        if (clr) begin
            m_cs[i] = 0;
            m_ovf[i] = 1'b0;
            nst = 0;
        end else begin
            if (tk && (m_st[i] == 1 || m_st[i] == 3)) begin
                if (m_cs[i] == m_max[i]) begin
                    m_ovf[i] = 1'b1;
                    if (m_sat[i]) sat_hit = 1'b1;
                    else m_cs[i] = 0;
                end else begin
                    m_cs[i]++;
                end
            end
            if (ss) nst = (m_st[i] == 1 || m_st[i] == 3) ? 2 : 1;
            else if (LapEn && lp && m_st[i] == 1) nst = 3;
            else if (LapEn && lp && m_st[i] == 3) nst = 1;
            else if (sat_hit) nst = 2;
        end
        if (nst == 3 && m_st[i] != 3) m_hold[i] = prev;
        m_st[i] = nst;
    endtask

    // One clock: drive, advance the model at the edge, sample 1 unit later.
    task automatic step(input bit ss, input bit ssc, input bit clr, input bit lp, input bit tk);
        logic [23:0] d;
        start_stop = ss; start_stop_c = ssc; clear = clr; lap = lp; tick_en = tk;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            if (!rst_sig(i)) model_reset(i);
            else if (skip[i] > 0) skip[i]--;
            else model_step(i, (i == 2) ? ssc : ss, clr, lp, tk);
        end
        #1;
        start_stop = 1'b0; start_stop_c = 1'b0; clear = 1'b0; lap = 1'b0; tick_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (obs(i) !== exp_vec(i)) track_err++;
            d = obs(i) >> 2;
            if (d[3:0] > 9 || d[7:4] > 9 || d[11:8] > 9 || d[15:12] > 5 || d[19:16] > 9 ||
                32'(d[23:20]) > m_mt[i]) bad_bcd++;
        end
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_ab = 1'b1; reset_c = 1'b1;
        tick_en = 1'b0; start_stop = 1'b0; start_stop_c = 1'b0; clear = 1'b0; lap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_reset(i);
            skip[i] = 0;
        end
        #2;
        reset_ab = 1'b0; reset_c = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_state_%0d", i), obs(i), 26'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_ab = 1'b1; reset_c = 1'b1;
        for (int i = 0; i < 3; i++) skip[i] = 2;
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(3);
        check("idle_no_count", disp0, 24'h000000);

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_running", run0, 1'b1);
        run_ticks(100);
        check("t100_disp", disp0, 24'h000100);
        check("t100_run", run0, 1'b1);
        run_ticks(5899);
        check("t5999_disp", disp0, 24'h005999);
        run_ticks(1);
        check("t6000_carry", disp0, 24'h010000);
        run_ticks(14145);
        check("dflt_at_32145", disp2, 24'h032145);

        // Reset only the default-parameter instance in mid-run.
        reset_c = 1'b0;
        #1;
        check("dflt_reset_imm", obs(2), 26'd0);
        model_reset(2);
        run_ticks(3);
        reset_c = 1'b1;
        skip[2] = 2;
        run_ticks(50);
        check("dflt_no_count_after_rst", obs(2), 26'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_ticks(5);
        check("dflt_restart", disp2, 24'h000005);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("dflt_ss_tick", {disp2, run2}, {24'h000006, 1'b0});
        run_ticks(50);
        check("dflt_paused_hold", disp2, 24'h000006);

        run_ticks(m_max[0] - m_cs[0]);
        check("sat_at_max", disp0, 24'h095999);
        check("wrap_at_max", disp1, 24'h095999);
        check("sat_ovf_before", ovf0, 1'b0);
        run_ticks(1);
        check("sat_hold", disp0, 24'h095999);
        check("sat_ovf", ovf0, 1'b1);
        check("sat_stopped", run0, 1'b0);
        check("wrap_zero", disp1, 24'h000000);
        check("wrap_ovf", ovf1, 1'b1);
        check("wrap_running", run1, 1'b1);
        run_ticks(1);
        check("sat_hold2", disp0, 24'h095999);
        check("wrap_counts_on", disp1, 24'h000001);
        check("track_long", track_err, 0);
        check("bcd_legal", bad_bcd, 0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("sat_clear", obs(0), 26'd0);
        check("wrap_clear", obs(1), 26'd0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(1000);
        check("pre_lap", disp0, 24'h001000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_entry", disp0, 24'h001000);
        run_ticks(200);
`ifdef STOPWATCH_LAP_HOLD_EN
        check("lap_frozen", disp0, 24'h001000);
        check("lap_running", run0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_release", disp0, 24'h001200);
`else
        check("lap_ignored", disp0, 24'h001200);
        check("lap_running", run0, 1'b1);
`endif

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)));
            for (int i = 0; i < 3; i++) check($sformatf("rand_dut%0d", i), obs(i), exp_vec(i));
        end
        check("bcd_legal_final", bad_bcd, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
